compositor_pixel_engine: RTL and testbench

Per-pixel compositing engine that consumes the draw/frame/display addresses produced by the compositor address generator and advances it via a one-cycle next pulse. For each pixel it reads the draw-buffer word, conditionally reads the frame-buffer word, merges them by colour-key or alpha blend, and writes the result to the display buffer. It runs one full frame per start command over a single req/ack memory port.

---
 rtl/compositor_pixel_engine.sv | 157 +++++++++++++++
 tb/tb_compositor_pixel_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compositor_pixel_engine.sv
// Per-pixel compositor: reads draw (and frame when needed), merges by colour key or alpha, writes display, steps the generator.
// First mem_req one cycle after an accepted start; every transfer stalls on mem_ack and req drops a cycle between transfers.
module compositor_pixel_engine #(
    parameter int ADDR_W = 32,
    parameter int PIX_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [23:0]       key_color,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              gen_next,
    input  logic              gen_done,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [ADDR_W-1:0] frame_addr,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_DRAW  = 3'd1,
        RD_FRAME = 3'd2,
        WRITE    = 3'd3,
        ADVANCE  = 3'd4,
        CHECK    = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               mode_lat;
    logic [23:0]        key_lat;
    logic [PIX_W-1:0]   draw_pix;
    logic [PIX_W-1:0]   out_pix;
    logic [PIX_W-1:0]   blend_pix;
    logic [PIX_W-1:0]   frame_pix;
    logic [8:0]         alpha;
    logic               xfer_done;
    logic               need_frame;

    // Weights sum to 256, so the 17-bit sum never exceeds 16 bits and >>8 fits a byte.
    function automatic logic [7:0] blend_ch(input logic [7:0] d, input logic [7:0] f, input logic [8:0] a);
        logic [16:0] s;
        s = 17'(d) * 17'(a) + 17'(f) * (17'd256 - 17'(a));
        return 8'(s >> 8);
    endfunction

    assign xfer_done  = mem_req & mem_ack;
    assign need_frame = mode_lat ? (mem_rdata[31:24] != 8'hFF) : (mem_rdata[23:0] == key_lat);
    assign alpha      = {1'b0, draw_pix[31:24]} + {8'd0, draw_pix[31]};
    assign blend_pix  = {8'hFF,
                         blend_ch(draw_pix[23:16], mem_rdata[23:16], alpha),
                         blend_ch(draw_pix[15:8],  mem_rdata[15:8],  alpha),
                         blend_ch(draw_pix[7:0],   mem_rdata[7:0],   alpha)};
    assign frame_pix  = mode_lat ? blend_pix : mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start)     state_nxt = RD_DRAW;
            RD_DRAW:  if (xfer_done) state_nxt = need_frame ? RD_FRAME : WRITE;
            RD_FRAME: if (xfer_done) state_nxt = WRITE;
            WRITE:    if (xfer_done) state_nxt = ADVANCE;
            ADVANCE:                 state_nxt = CHECK;
            CHECK:                   state_nxt = gen_done ? IDLE : RD_DRAW;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        gen_next   = (state == ADVANCE);
        frame_done = (state == CHECK) && gen_done;
    end

    // The draw read is launched on the edge that enters RD_DRAW so a pixel needs no idle gap before it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mode_lat    <= 1'b0;
            key_lat     <= '0;
            draw_pix    <= '0;
            out_pix     <= '0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_lat <= mode;
                        key_lat  <= key_color;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= draw_addr;
                    end
                end
                RD_DRAW: begin
                    if (xfer_done) begin
                        mem_req  <= 1'b0;
                        draw_pix <= mem_rdata;
                        out_pix  <= mem_rdata;
                    end
                end
                RD_FRAME: begin
                    if (xfer_done) begin
                        mem_req <= 1'b0;
                        out_pix <= frame_pix;
                    end else if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= frame_addr;
                    end
                end
                WRITE: begin
                    if (xfer_done) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= disp_addr;
                        mem_wdata <= out_pix;
                    end
                end
                CHECK: begin
                    if (gen_done) begin
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= draw_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_compositor_pixel_engine.sv
// Bench for compositor_pixel_engine: behavioural generator and memory, write scoreboard, random ack latency.
`timescale 1ns/1ps
module tb_compositor_pixel_engine;
    localparam int ADDR_W  = 32;
    localparam int PIX_W   = 32;
    localparam int MAX_PIX = 64;
    localparam logic [31:0] DRAW_BASE  = 32'h1000_0000;
    localparam logic [31:0] FRAME_BASE = 32'h2000_0000;
    localparam logic [31:0] DISP_BASE  = 32'h3000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [23:0]       key_color = '0;
    logic              busy, frame_done, gen_next, gen_done;
    logic [15:0]       frame_count;
    logic [ADDR_W-1:0] draw_addr, frame_addr, disp_addr, mem_addr;
    logic              mem_req, mem_we;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata = '0;
    logic              mem_ack = 1'b0;

    always #5 clk = ~clk;

    compositor_pixel_engine #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .key_color(key_color),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count), .gen_next(gen_next),
        .gen_done(gen_done), .draw_addr(draw_addr), .frame_addr(frame_addr), .disp_addr(disp_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Address generator stand-in: linear index over frame_len pixels.
    int frame_len = 1;
    int gidx = 0;
    assign gen_done   = (gidx == 0);
    assign draw_addr  = DRAW_BASE  + 32'(gidx << 2);
    assign frame_addr = FRAME_BASE + 32'(gidx << 2);
    assign disp_addr  = DISP_BASE  + 32'(gidx << 2);

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] draw_mem  [MAX_PIX];
    logic [31:0] frame_mem [MAX_PIX];
    wr_t         exp_q[$];
    logic [15:0] fc_exp = '0;
    logic [31:0] last_wdata = '0;

    int max_wait = 0;
    bit hold_ack = 1'b0;
    bit in_xfer = 1'b0;
    bit acked_last = 1'b0;
    int wait_cnt = 0;
    int n_wr = 0, n_rd = 0, n_done = 0, n_next = 0, proto_err = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;

    // Memory responder and event monitor; decides the ack for the coming edge.
    always @(negedge clk) begin : resp
        wr_t e;
        int  idx;
        if (frame_done) n_done++;
        if (gen_next) begin
            n_next++;
            gidx = (gidx + 1) % frame_len;
        end
        if (mem_req) begin
            if (acked_last) proto_err++;
            if (!in_xfer) begin
                in_xfer   = 1'b1;
                cap_addr  = mem_addr;
                cap_we    = mem_we;
                cap_wdata = mem_wdata;
                wait_cnt  = (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
            end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
                proto_err++;
            end
            if (!hold_ack && wait_cnt == 0) begin
                mem_ack    = 1'b1;
                in_xfer    = 1'b0;
                acked_last = 1'b1;
                if (mem_we) begin
                    n_wr++;
                    last_wdata = mem_wdata;
                    if (exp_q.size() == 0) begin
                        check("wr_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", mem_addr, e.addr);
                        check("wr_data", mem_wdata, e.data);
                    end
                end else begin
                    n_rd++;
                    if (mem_addr >= DRAW_BASE && mem_addr < DRAW_BASE + 32'(MAX_PIX * 4)) begin
                        idx = int'((mem_addr - DRAW_BASE) >> 2);
                        mem_rdata = draw_mem[idx];
                    end else if (mem_addr >= FRAME_BASE && mem_addr < FRAME_BASE + 32'(MAX_PIX * 4)) begin
                        idx = int'((mem_addr - FRAME_BASE) >> 2);
                        mem_rdata = frame_mem[idx];
                    end else begin
                        proto_err++;
                        mem_rdata = 32'hDEAD_BEEF;
                    end
                end
            end else begin
                mem_ack    = 1'b0;
                acked_last = 1'b0;
                if (wait_cnt > 0) wait_cnt--;
            end
        end else begin
            in_xfer    = 1'b0;
            acked_last = 1'b0;
            mem_ack    = (max_wait > 0) && ($urandom_range(0, 3) == 0);
            mem_rdata  = $urandom;
        end
    end

    function automatic void model(input logic m, input logic [23:0] k, input logic [31:0] d,
                                  input logic [31:0] f, output logic [31:0] p, output int reads);
        int a;
        p = '0;
        if (!m) begin
            reads = (d[23:0] == k) ? 2 : 1;
            p     = (d[23:0] == k) ? f : d;
        end else if (d[31:24] == 8'hFF) begin
            reads = 1;
            p     = {8'hFF, d[23:0]};
        end else begin
            reads = 2;
            a = int'(d[31:24]) + (d[31] ? 1 : 0);
            p[31:24] = 8'hFF;
            for (int c = 0; c < 3; c++) begin
                p[8*c +: 8] = 8'((int'(d[8*c +: 8]) * a + int'(f[8*c +: 8]) * (256 - a)) / 256);
            end
        end
    endfunction

    task automatic run_frame(input string tag, input logic m, input logic [23:0] k, input int mw, input bit extra_starts);
        logic [31:0] p;
        int r, exp_reads, cyc, b_wr, b_rd, b_done, b_next;
        bit seen;
        exp_reads = 0;
        for (int i = 0; i < frame_len; i++) begin
            model(m, k, draw_mem[i], frame_mem[i], p, r);
            exp_q.push_back('{DISP_BASE + 32'(i * 4), p});
            exp_reads += r;
        end
        b_wr = n_wr; b_rd = n_rd; b_done = n_done; b_next = n_next;
        max_wait = mw;
        @(negedge clk);
        mode = m; key_color = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = ~m; key_color = ~k;
        check({tag, "_req_lat"}, mem_req, 1);
        check({tag, "_first_addr"}, mem_addr, DRAW_BASE);
        check({tag, "_busy"}, busy, 1);
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = extra_starts && (cyc % 37 == 0);
            if (frame_done) begin
                seen = 1'b1;
                if (extra_starts) start = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        fc_exp = fc_exp + 16'd1;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_done_pulses"}, n_done - b_done, 1);
        check({tag, "_writes"}, n_wr - b_wr, frame_len);
        check({tag, "_reads"}, n_rd - b_rd, exp_reads);
        check({tag, "_gen_next"}, n_next - b_next, frame_len);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_req_after"}, mem_req, 0);
        check({tag, "_frame_count"}, frame_count, fc_exp);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < MAX_PIX; i++) begin
            draw_mem[i]  = '0;
            frame_mem[i] = '0;
        end
        #2 rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_gen_next", gen_next, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_frame_count", frame_count, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        frame_len = 1;
        draw_mem[0] = 32'h1234_5678; frame_mem[0] = 32'h5555_AAAA;
        run_frame("key_miss", 1'b0, 24'h00FF00, 0, 1'b0);
        check("key_miss_disp", last_wdata, 32'h1234_5678);

        draw_mem[0] = 32'h0000_FF00; frame_mem[0] = 32'hAABB_CCDD;
        run_frame("key_hit", 1'b0, 24'h00FF00, 0, 1'b0);
        check("key_hit_disp", last_wdata, 32'hAABB_CCDD);

        // a=129: R=255*129>>8=0x80, B=255*127>>8=0x7E
        draw_mem[0] = 32'h80FF_0000; frame_mem[0] = 32'h0000_00FF;
        run_frame("blend_mid", 1'b1, 24'h0, 0, 1'b0);
        check("blend_mid_disp", last_wdata, 32'hFF80_007E);

        draw_mem[0] = 32'hFF12_3456; frame_mem[0] = 32'h1122_3344;
        run_frame("blend_opaque", 1'b1, 24'h0, 0, 1'b0);
        check("blend_opaque_disp", last_wdata, 32'hFF12_3456);

        draw_mem[0] = 32'h0012_3456; frame_mem[0] = 32'h77AB_CDEF;
        run_frame("blend_clear", 1'b1, 24'h0, 0, 1'b0);
        check("blend_clear_disp", last_wdata, 32'hFFAB_CDEF);

        frame_len = MAX_PIX;
        for (int i = 0; i < MAX_PIX; i++) begin
            draw_mem[i]  = $urandom;
            frame_mem[i] = $urandom;
            if ($urandom_range(0, 3) == 0) draw_mem[i][23:0] = 24'h00FF00;
        end
        run_frame("key_frame", 1'b0, 24'h00FF00, 5, 1'b1);

        for (int i = 0; i < MAX_PIX; i++) begin
            draw_mem[i]  = $urandom;
            frame_mem[i] = $urandom;
            case ($urandom_range(0, 3))
                0: draw_mem[i][31:24] = 8'hFF;
                1: draw_mem[i][31:24] = 8'h00;
                default: ;
            endcase
        end
        run_frame("blend_frame", 1'b1, 24'h0, 5, 1'b1);

        frame_len = 1;
        gidx = 0;
        hold_ack = 1'b1;
        max_wait = 0;
        @(negedge clk);
        mode = 1'b0; key_color = 24'h00FF00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_mid_req_up", mem_req, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_we", mem_we, 0);
        check("rst_mid_addr", mem_addr, 0);
        check("rst_mid_count", frame_count, 0);
        exp_q.delete();
        hold_ack = 1'b0;
        gidx = 0;
        fc_exp = '0;
        @(negedge clk);
        rst = 1'b1;

        frame_len = 4;
        for (int i = 0; i < 4; i++) begin
            draw_mem[i]  = $urandom;
            frame_mem[i] = $urandom;
        end
        draw_mem[1][23:0] = 24'h00FF00;
        run_frame("post_rst", 1'b0, 24'h00FF00, 3, 1'b0);

        check("protocol_errors", proto_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
